// File: rtl/hazard_pkg.sv
// Shared types and constants for the LEGv8 hazard/forwarding controller.
package hazard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_e;

  localparam logic [4:0] XZR = 5'd31;

  // Producer stage indices into the per-stage match vectors.
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  // Total stall length in cycles, counting the detection cycle.
  localparam logic [1:0] N_NONE     = 2'd0;
  localparam logic [1:0] N_LOAD_USE = 2'd1;
  localparam logic [1:0] N_EX       = 2'd3;
  localparam logic [1:0] N_MEM      = 2'd2;
  localparam logic [1:0] N_WB       = 2'd1;
  localparam logic [1:0] N_FLAG     = 2'd1;

  // The younger producer (EX/MEM) always holds the newer value.
  function automatic fwd_e fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_EXMEM;
    else if (wb_hit) return FWD_MEMWB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side bundle of hazard_unit: stage fields in, enables/flushes/selects out.
interface hazard_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       idRn, idRm;
  logic             idUseA, idUseB, idReadsFlags;
  logic [4:0]       exRd;
  logic             exRegWrite, exload, exsetFlag, exBrTaken;
  logic [4:0]       memRd;
  logic             memRegWrite;
  logic [4:0]       wbRd;
  logic             wbRegWrite;
  logic             pcWrEn, ifidWrEn, idexWrEn, exmemWrEn, memwbWrEn;
  logic             ifidFlush, idexFlush;
  logic [1:0]       fwdA, fwdB;
  logic             fwdFlags;
  logic [CNT_W-1:0] stallCycles, flushEvents;

  modport master (
    output idRn, idRm, idUseA, idUseB, idReadsFlags,
    output exRd, exRegWrite, exload, exsetFlag, exBrTaken,
    output memRd, memRegWrite, wbRd, wbRegWrite,
    input  pcWrEn, ifidWrEn, idexWrEn, exmemWrEn, memwbWrEn,
    input  ifidFlush, idexFlush, fwdA, fwdB, fwdFlags,
    input  stallCycles, flushEvents
  );

  modport slave (
    input  idRn, idRm, idUseA, idUseB, idReadsFlags,
    input  exRd, exRegWrite, exload, exsetFlag, exBrTaken,
    input  memRd, memRegWrite, wbRd, wbRegWrite,
    output pcWrEn, ifidWrEn, idexWrEn, exmemWrEn, memwbWrEn,
    output ifidFlush, idexFlush, fwdA, fwdB, fwdFlags,
    output stallCycles, flushEvents
  );

endinterface

// File: rtl/hazard_match.sv
// One producer stage's Rd/RegWrite compared against both ID source registers.
module hazard_match
  import hazard_pkg::*;
(
  input  logic [4:0] rd,
  input  logic       reg_write,
  input  logic [4:0] rn,
  input  logic [4:0] rm,
  input  logic       use_a,
  input  logic       use_b,
  output logic       match_a,
  output logic       match_b
);

  // XZR reads as zero, so a write to it is never a real producer.
  logic producer_valid;
  assign producer_valid = reg_write && (rd != XZR);

  assign match_a = producer_valid && use_a && (rd == rn);
  assign match_b = producer_valid && use_b && (rd == rm);

endmodule

// File: rtl/hazard_unit.sv
// Hazard/forwarding controller for the five-stage LEGv8 pipeline.
// Define HAZARD_FWD_EN to compile in operand/flag forwarding (load-use stalls only).
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_unit_if.slave hz
);

  state_e           state_reg;
  logic [1:0]       wait_cnt_reg;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  logic [4:0] stage_rd [3];
  logic [2:0] stage_we, match_a, match_b, stage_hit;

  assign stage_rd[STG_EX]  = hz.exRd;
  assign stage_rd[STG_MEM] = hz.memRd;
  assign stage_rd[STG_WB]  = hz.wbRd;
  assign stage_we          = {hz.wbRegWrite, hz.memRegWrite, hz.exRegWrite};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_match
      hazard_match u_match (
        .rd        (stage_rd[gi]),
        .reg_write (stage_we[gi]),
        .rn        (hz.idRn),
        .rm        (hz.idRm),
        .use_a     (hz.idUseA),
        .use_b     (hz.idUseB),
        .match_a   (match_a[gi]),
        .match_b   (match_b[gi])
      );
    end
  endgenerate

  assign stage_hit = match_a | match_b;

  logic [1:0] stall_len;
  logic       flag_hit;
  assign flag_hit = hz.exsetFlag && hz.idReadsFlags;

`ifdef HAZARD_FWD_EN
  logic [1:0] unused_hits;
  assign unused_hits = stage_hit[STG_WB:STG_MEM];

  always_comb begin
    stall_len = N_NONE;
    if (hz.exload && stage_hit[STG_EX]) stall_len = N_LOAD_USE;
  end
`else
  logic unused_exload;
  assign unused_exload = hz.exload;

  // Priority order equals the maximum over all matching producers.
  always_comb begin
    stall_len = N_NONE;
    if (stage_hit[STG_EX])                stall_len = N_EX;
    else if (stage_hit[STG_MEM])          stall_len = N_MEM;
    else if (stage_hit[STG_WB])           stall_len = N_WB;
    else if (flag_hit)                    stall_len = N_FLAG;
  end
`endif

  // A taken branch squashes the ID instruction, so it can never cause a stall.
  logic stall_now;
  assign stall_now = !hz.exBrTaken && ((state_reg == WAIT) || (stall_len != N_NONE));

  logic pc_wr_en, ifid_flush, idex_flush, fwd_flags;
  fwd_e fwd_a, fwd_b;

  always_comb begin
    pc_wr_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    fwd_a      = FWD_RF;
    fwd_b      = FWD_RF;
    fwd_flags  = 1'b0;
    if (!reset) begin
      pc_wr_en   = !stall_now;
      ifid_flush = hz.exBrTaken;
      idex_flush = hz.exBrTaken || stall_now;
`ifdef HAZARD_FWD_EN
      fwd_a      = fwd_sel(match_a[STG_MEM], match_a[STG_WB]);
      fwd_b      = fwd_sel(match_b[STG_MEM], match_b[STG_WB]);
      fwd_flags  = flag_hit;
`endif
    end
  end

  assign hz.pcWrEn      = pc_wr_en;
  assign hz.ifidWrEn    = pc_wr_en;
  assign hz.idexWrEn    = 1'b1;
  assign hz.exmemWrEn   = 1'b1;
  assign hz.memwbWrEn   = 1'b1;
  assign hz.ifidFlush   = ifid_flush;
  assign hz.idexFlush   = idex_flush;
  assign hz.fwdA        = fwd_a;
  assign hz.fwdB        = fwd_b;
  assign hz.fwdFlags    = fwd_flags;
  assign hz.stallCycles = reset ? '0 : stall_cnt_reg;
  assign hz.flushEvents = reset ? '0 : flush_cnt_reg;

  // The detection cycle is the first stall cycle; WAIT covers the remaining N-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= 2'd0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (hz.exBrTaken) begin
        state_reg    <= RUN;
        wait_cnt_reg <= 2'd0;
        if (flush_cnt_reg != '1) flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end else if (state_reg == RUN) begin
        wait_cnt_reg <= (stall_len == N_NONE) ? 2'd0 : stall_len - 2'd1;
        if (stall_len > N_LOAD_USE) state_reg <= WAIT;
      end else begin
        wait_cnt_reg <= (wait_cnt_reg == 2'd0) ? 2'd0 : wait_cnt_reg - 2'd1;
        if (wait_cnt_reg <= 2'd1) state_reg <= RUN;
      end

      if (!pc_wr_en && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; expectations follow the HAZARD_FWD_EN build setting.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  // {pcWrEn, ifidWrEn, ifidFlush, idexFlush}
  localparam logic [31:0] CTL_RUN   = 32'hC;
  localparam logic [31:0] CTL_STALL = 32'h1;
  localparam logic [31:0] CTL_BR    = 32'hF;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  hazard_unit_if #(.CNT_W(CNT_W)) h ();

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (h)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    h.idRn = 5'd0; h.idRm = 5'd0; h.idUseA = 1'b0; h.idUseB = 1'b0; h.idReadsFlags = 1'b0;
    h.exRd = 5'd0; h.exRegWrite = 1'b0; h.exload = 1'b0; h.exsetFlag = 1'b0; h.exBrTaken = 1'b0;
    h.memRd = 5'd0; h.memRegWrite = 1'b0; h.wbRd = 5'd0; h.wbRegWrite = 1'b0;
  endtask

  function automatic logic [31:0] ctl();
    return 32'({h.pcWrEn, h.ifidWrEn, h.ifidFlush, h.idexFlush});
  endfunction

  task automatic expect_run(input string tag);
    #1;
    chk(tag, ctl(), CTL_RUN);
  endtask

  task automatic expect_stall(input string tag);
    #1;
    chk(tag, ctl(), CTL_STALL);
    exp_stall++;
  endtask

  task automatic expect_branch(input string tag);
    #1;
    chk(tag, ctl(), CTL_BR);
    exp_flush++;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_stall"}, 32'(h.stallCycles), 32'(sat(exp_stall)));
    chk({tag, "_flush"}, 32'(h.flushEvents), 32'(sat(exp_flush)));
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    // Hazard-looking inputs during reset must not leak to the outputs.
    h.exRd = 5'd3; h.exRegWrite = 1'b1; h.idRn = 5'd3; h.idUseA = 1'b1;
    h.memRd = 5'd3; h.memRegWrite = 1'b1; h.exsetFlag = 1'b1; h.idReadsFlags = 1'b1; h.exBrTaken = 1'b1;
    expect_run("reset_ctl");
    chk("reset_fwd", 32'({h.fwdA, h.fwdB, h.fwdFlags}), 32'h0);
    check_counters("reset");

    step(); reset = 1'b0; clear_inputs();
    expect_run("idle_ctl");
    chk("idle_back_en", 32'({h.idexWrEn, h.exmemWrEn, h.memwbWrEn}), 32'h7);

    // X3 produced in EX, then walks to MEM and WB while ID reads it as Rn.
    step(); h.exRd = 5'd3; h.exRegWrite = 1'b1; h.idRn = 5'd3; h.idUseA = 1'b1;
`ifdef HAZARD_FWD_EN
    expect_run("x3_ex"); chk("x3_ex_fwdA", 32'(h.fwdA), 32'(FWD_RF));
`else
    expect_stall("x3_ex");
`endif
    step(); h.exRegWrite = 1'b0; h.memRd = 5'd3; h.memRegWrite = 1'b1;
`ifdef HAZARD_FWD_EN
    expect_run("x3_mem"); chk("x3_mem_fwdA", 32'(h.fwdA), 32'(FWD_EXMEM));
`else
    expect_stall("x3_mem");
`endif
    step(); h.memRegWrite = 1'b0; h.wbRd = 5'd3; h.wbRegWrite = 1'b1;
`ifdef HAZARD_FWD_EN
    expect_run("x3_wb"); chk("x3_wb_fwdA", 32'(h.fwdA), 32'(FWD_MEMWB));
`else
    expect_stall("x3_wb");
`endif
    step(); clear_inputs();
    expect_run("x3_done");
    check_counters("x3");

    // Load-use on Rm.
    step(); h.exRd = 5'd2; h.exRegWrite = 1'b1; h.exload = 1'b1; h.idRm = 5'd2; h.idUseB = 1'b1;
    expect_stall("lu_detect");
    step(); h.exRegWrite = 1'b0; h.exload = 1'b0; h.wbRd = 5'd2; h.wbRegWrite = 1'b1;
`ifdef HAZARD_FWD_EN
    expect_run("lu_resume"); chk("lu_fwdB", 32'(h.fwdB), 32'(FWD_MEMWB));
`else
    expect_stall("lu_wait1");
    step(); expect_stall("lu_wait2");
    step(); clear_inputs(); expect_run("lu_resume");
`endif
    check_counters("lu");

    // Taken branch together with a load-use match.
    step(); clear_inputs();
    h.exRd = 5'd2; h.exRegWrite = 1'b1; h.exload = 1'b1; h.idRm = 5'd2; h.idUseB = 1'b1; h.exBrTaken = 1'b1;
    expect_branch("br_lu");
    step(); clear_inputs();
    expect_run("br_after");
    check_counters("br");

    // XZR is never a producer.
    step(); h.exRd = 5'd31; h.exRegWrite = 1'b1; h.exload = 1'b1; h.idRn = 5'd31; h.idUseA = 1'b1;
    h.idRm = 5'd31; h.idUseB = 1'b1; h.memRd = 5'd31; h.memRegWrite = 1'b1; h.wbRd = 5'd31; h.wbRegWrite = 1'b1;
    expect_run("xzr_ctl");
    chk("xzr_fwd", 32'({h.fwdA, h.fwdB}), 32'h0);

    // Unused sources and non-writing producers are ignored.
    step(); clear_inputs(); h.exRd = 5'd4; h.exRegWrite = 1'b1; h.exload = 1'b1; h.idRn = 5'd4; h.idRm = 5'd4;
    expect_run("nouse");
    step(); h.exRegWrite = 1'b0; h.idUseA = 1'b1; h.idUseB = 1'b1;
    expect_run("nowrite");

    // Flag dependency of a B.cond.
    step(); clear_inputs(); h.exsetFlag = 1'b1; h.idReadsFlags = 1'b1;
`ifdef HAZARD_FWD_EN
    expect_run("flag"); chk("flag_fwd", 32'(h.fwdFlags), 32'h1);
`else
    expect_stall("flag"); chk("flag_fwd", 32'(h.fwdFlags), 32'h0);
`endif
    step(); h.idReadsFlags = 1'b0;
    expect_run("flag_none");
    chk("flag_none_fwd", 32'(h.fwdFlags), 32'h0);

    // MEM match on Rn combined with WB match on Rm.
    step(); clear_inputs();
    h.memRd = 5'd5; h.memRegWrite = 1'b1; h.idRn = 5'd5; h.idUseA = 1'b1;
    h.wbRd = 5'd6; h.wbRegWrite = 1'b1; h.idRm = 5'd6; h.idUseB = 1'b1;
`ifdef HAZARD_FWD_EN
    expect_run("memwb");
    chk("memwb_fwd", 32'({h.fwdA, h.fwdB}), 32'({FWD_EXMEM, FWD_MEMWB}));
    step(); h.memRd = 5'd7; h.wbRd = 5'd7; h.idRn = 5'd7; h.idRm = 5'd7;
    expect_run("both_stages");
    chk("both_prio", 32'({h.fwdA, h.fwdB}), 32'({FWD_EXMEM, FWD_EXMEM}));
    step(); h.memRegWrite = 1'b0;
    chk("wb_only_fwd", 32'({h.fwdA, h.fwdB}), 32'({FWD_MEMWB, FWD_MEMWB}));
`else
    expect_stall("memwb_detect");
    step(); expect_stall("memwb_wait");
    step(); clear_inputs(); expect_run("memwb_done");
    step(); h.wbRd = 5'd6; h.wbRegWrite = 1'b1; h.idRm = 5'd6; h.idUseB = 1'b1;
    expect_stall("wb_only");
    step(); clear_inputs(); expect_run("wb_only_done");
`endif
    check_counters("memwb");

    // Taken branch arriving while a stall is in progress.
    step(); clear_inputs(); h.exRd = 5'd3; h.exRegWrite = 1'b1; h.idRn = 5'd3; h.idUseA = 1'b1;
`ifdef HAZARD_FWD_EN
    expect_run("brw_detect");
`else
    expect_stall("brw_detect");
`endif
    step(); h.exBrTaken = 1'b1;
    expect_branch("brw_branch");
    step(); clear_inputs();
    expect_run("brw_after");
    check_counters("brw");

    // Reset asserted in the second WAIT cycle of a long stall.
    step(); h.exRd = 5'd3; h.exRegWrite = 1'b1; h.idRn = 5'd3; h.idUseA = 1'b1;
`ifdef HAZARD_FWD_EN
    expect_run("rw_detect");
    step(); expect_run("rw_wait1");
`else
    expect_stall("rw_detect");
    step(); expect_stall("rw_wait1");
`endif
    step(); reset = 1'b1;
    exp_stall = 0; exp_flush = 0;
    expect_run("rw_reset_ctl");
    check_counters("rw_reset");
    step(); reset = 1'b0; clear_inputs();
    expect_run("rw_after");
    check_counters("rw_after");
    step(); expect_run("rw_after2");

    // Continuous load-use pressure drives stallCycles into saturation.
    step(); h.exRd = 5'd2; h.exRegWrite = 1'b1; h.exload = 1'b1; h.idRm = 5'd2; h.idUseB = 1'b1;
    expect_stall("sat_stall_0");
    for (int i = 1; i < 21; i++) begin
      step(); expect_stall($sformatf("sat_stall_%0d", i));
    end
    step(); clear_inputs();
    expect_run("sat_stall_done");
    check_counters("sat_stall");

    for (int i = 0; i < 16; i++) begin
      step(); h.exBrTaken = 1'b1; expect_branch($sformatf("sat_br_%0d", i));
    end
    step(); clear_inputs();
    expect_run("sat_br_done");
    check_counters("sat_br");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
